// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the vga_adapter plot port; each engine keeps the port for a whole burst ending on last.
// One-cycle accept-to-plot latency; an owner silent for TIMEOUT cycles is released with an abort pulse.
module vga_plot_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     last,
    input  logic [8*N-1:0]   x_in,
    input  logic [7*N-1:0]   y_in,
    input  logic [3*N-1:0]   colour_in,
    output logic [N-1:0]     gnt,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [2:0]       colour,
    output logic             plot,
    output logic             busy,
    output logic [N-1:0]     abort
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   own;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;
    logic [IW-1:0]   nxt;
    logic            found;
    logic [7:0]      icnt;

    logic [7:0]      xa [N];
    logic [6:0]      ya [N];
    logic [2:0]      ca [N];

    for (genvar i = 0; i < N; i++) begin : g_unpack
        assign xa[i] = x_in[8*i +: 8];
        assign ya[i] = y_in[7*i +: 7];
        assign ca[i] = colour_in[3*i +: 3];
    end

    // First requester at or after ptr, wrapping modulo N.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign nxt = (own == IW'(N - 1)) ? '0 : own + 1'b1;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            gnt    <= '0;
            ptr    <= '0;
            own    <= '0;
            icnt   <= '0;
            x      <= '0;
            y      <= '0;
            colour <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            abort  <= '0;
        end else begin
            abort <= '0;
            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    if (found) begin
                        gnt   <= N'(1) << pick;
                        own   <= pick;
                        icnt  <= '0;
                        state <= BURST;
                        busy  <= 1'b1;
                    end
                end
                BURST: begin
                    if (req[own]) begin
                        x      <= xa[own];
                        y      <= ya[own];
                        colour <= ca[own];
                        plot   <= 1'b1;
                        icnt   <= '0;
                        if (last[own]) begin
                            gnt   <= '0;
                            ptr   <= nxt;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        plot <= 1'b0;
                        // icnt holds the idle edges already seen; this edge is the TIMEOUT-th.
                        if (icnt == 8'(TIMEOUT - 1)) begin
                            gnt        <= '0;
                            ptr        <= nxt;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            abort[own] <= 1'b1;
                        end else begin
                            icnt <= icnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: vector table, directed corner sequences and random traffic vs a transaction model.
module tb_vga_plot_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   last = '0;
    logic [7:0]     px [N];
    logic [6:0]     py [N];
    logic [2:0]     pc [N];
    logic [8*N-1:0] x_in;
    logic [7*N-1:0] y_in;
    logic [3*N-1:0] colour_in;
    logic [N-1:0]   gnt;
    logic [7:0]     x;
    logic [6:0]     y;
    logic [2:0]     colour;
    logic           plot;
    logic           busy;
    logic [N-1:0]   abort;

    int checks = 0;
    int failures = 0;

    int m_own, m_ptr, m_idle;
    int m_gnt, m_x, m_y, m_c, m_plot, m_busy, m_abort;

    always #5 clk = ~clk;

    always_comb begin
        x_in = '0;
        y_in = '0;
        colour_in = '0;
        for (int i = 0; i < N; i++) begin
            x_in[8*i +: 8]      = px[i];
            y_in[7*i +: 7]      = py[i];
            colour_in[3*i +: 3] = pc[i];
        end
    end

    vga_plot_arbiter #(.N(N), .TIMEOUT(TO)) dut (
        .CLOCK_50(clk), .reset(reset), .req(req), .last(last),
        .x_in(x_in), .y_in(y_in), .colour_in(colour_in),
        .gnt(gnt), .x(x), .y(y), .colour(colour), .plot(plot),
        .busy(busy), .abort(abort)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_ptr = 0; m_idle = 0;
        m_gnt = 0; m_x = 0; m_y = 0; m_c = 0; m_plot = 0; m_busy = 0; m_abort = 0;
    endtask

    // Transaction view: who owns the port, whose turn is next, how long the owner has been silent.
    task automatic model_edge();
        m_abort = 0;
        if (m_own < 0) begin
            m_plot = 0;
            for (int k = 0; k < N; k++)
                if (m_own < 0 && req[(m_ptr + k) % N]) begin
                    m_own  = (m_ptr + k) % N;
                    m_idle = 0;
                end
        end else if (req[m_own]) begin
            m_x = px[m_own]; m_y = py[m_own]; m_c = pc[m_own];
            m_plot = 1; m_idle = 0;
            if (last[m_own]) begin
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end else begin
            m_plot = 0;
            m_idle++;
            if (m_idle == TO) begin
                m_abort = 1 << m_own;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
            end
        end
        m_gnt  = (m_own < 0) ? 0 : (1 << m_own);
        m_busy = (m_own >= 0) ? 1 : 0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("gnt", int'(gnt), m_gnt);
        chk("x", int'(x), m_x);
        chk("y", int'(y), m_y);
        chk("colour", int'(colour), m_c);
        chk("plot", int'(plot), m_plot);
        chk("busy", int'(busy), m_busy);
        chk("abort", int'(abort), m_abort);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_abort", int'(abort), 0);
        model_reset();
        req = '0;
        last = '0;
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] last;
        logic [3:0] gnt;
        logic       plot;
        logic [7:0] x;
        logic       busy;
    } vec_t;

    vec_t tv [12];
    int   order [$];
    int   cnt [N];
    logic [N-1:0] g_before, r_before;
    int   idle_edges, abort_seen;
    logic [3:0] pat;

    initial begin
        tv[0]  = '{4'b1000, 4'b0000, 4'b1000, 1'b0, 8'd0,  1'b1};
        tv[1]  = '{4'b1000, 4'b1000, 4'b0000, 1'b1, 8'd40, 1'b0};
        tv[2]  = '{4'b0011, 4'b0000, 4'b0001, 1'b0, 8'd40, 1'b1};
        tv[3]  = '{4'b0011, 4'b0001, 4'b0000, 1'b1, 8'd10, 1'b0};
        tv[4]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0, 8'd10, 1'b1};
        tv[5]  = '{4'b0001, 4'b0000, 4'b0010, 1'b0, 8'd10, 1'b1};
        tv[6]  = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 8'd20, 1'b0};
        tv[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 8'd20, 1'b0};
        tv[8]  = '{4'b0101, 4'b0000, 4'b0100, 1'b0, 8'd20, 1'b1};
        tv[9]  = '{4'b0100, 4'b0100, 4'b0000, 1'b1, 8'd30, 1'b0};
        tv[10] = '{4'b0001, 4'b0000, 4'b0001, 1'b0, 8'd30, 1'b1};
        tv[11] = '{4'b1001, 4'b0001, 4'b0000, 1'b1, 8'd10, 1'b0};

        for (int i = 0; i < N; i++) begin
            px[i] = 8'(10 * (i + 1));
            py[i] = '0;
            pc[i] = '0;
        end
        model_reset();
        #12 reset = 1'b0;
        step();

        // Start a burst on requester 1, then reset between edges mid-burst.
        req = 4'b0010;
        step();
        step();
        do_reset();

        for (int v = 0; v < 12; v++) begin
            req  = tv[v].req;
            last = tv[v].last;
            step();
            chk($sformatf("tv%0d_gnt", v), int'(gnt), int'(tv[v].gnt));
            chk($sformatf("tv%0d_plot", v), int'(plot), int'(tv[v].plot));
            chk($sformatf("tv%0d_x", v), int'(x), int'(tv[v].x));
            chk($sformatf("tv%0d_busy", v), int'(busy), int'(tv[v].busy));
        end
        req = '0; last = '0;
        step();

        // Single 16-pixel burst from requester 1 (ptr is 1 here).
        req = 4'b0010;
        step();
        chk("sb_gnt", int'(gnt), 2);
        for (int p = 0; p < 16; p++) begin
            px[1] = 8'(10 + p); py[1] = 7'd20; pc[1] = 3'b100;
            last = (p == 15) ? 4'b0010 : 4'b0000;
            step();
            chk("sb_plot", int'(plot), 1);
            chk("sb_x", int'(x), 10 + p);
            chk("sb_gnt_during", int'(gnt), (p == 15) ? 0 : 2);
        end
        req = '0; last = '0;
        step();
        chk("sb_plot_end", int'(plot), 0);
        req = 4'b1011;
        step();
        chk("sb_ptr2", int'(gnt), 8);
        req = 4'b1000; last = 4'b1000;
        step();
        req = '0; last = '0;
        step();

        // Round robin with all four requesting, 4-pixel bursts each.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            req = 4'b1111;
            for (int i = 0; i < N; i++) last[i] = (cnt[i] == 3);
            g_before = gnt;
            r_before = req;
            step();
            if (g_before == 0 && gnt != 0)
                for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            for (int i = 0; i < N; i++)
                if (g_before[i] && r_before[i]) cnt[i] = (cnt[i] + 1) % 4;
        end
        chk("rr_count", order.size(), 5);
        for (int i = 0; i < order.size() && i < 5; i++)
            chk($sformatf("rr_order%0d", i), order[i], i % 4);

        // Stalled owner: requester 2 sends 3 pixels then goes silent.
        do_reset();
        req = 4'b0100; last = '0;
        step();
        chk("st_gnt", int'(gnt), 4);
        for (int p = 0; p < 3; p++) step();
        req = 4'b1000;
        idle_edges = 0;
        abort_seen = 0;
        for (int c = 0; c < 30 && abort_seen == 0; c++) begin
            step();
            idle_edges++;
            if (abort != 0) abort_seen = 1;
        end
        chk("st_abort_seen", abort_seen, 1);
        chk("st_abort", int'(abort), 4);
        chk("st_idle_edges", idle_edges, TO);
        chk("st_gnt_rel", int'(gnt), 0);
        step();
        chk("st_next_gnt", int'(gnt), 8);
        chk("st_abort_pulse", int'(abort), 0);

        // Gapped burst by requester 3.
        pat = 4'b0101;
        for (int k = 0; k < 5; k++) begin
            req  = (k == 4 || pat[k]) ? 4'b1000 : 4'b0000;
            last = (k == 4) ? 4'b1000 : 4'b0000;
            step();
            chk("gap_plot", int'(plot), (k == 4 || pat[k]) ? 1 : 0);
            chk("gap_abort", int'(abort), 0);
        end
        chk("gap_done", int'(gnt), 0);

        // Non-owner isolation: requester 3 chatters with x=99 while 0 owns.
        req = 4'b0001; last = '0;
        step();
        px[3] = 8'd99;
        for (int k = 0; k < 6; k++) begin
            req  = {k[0], 3'b001};
            last = {k[0], 2'b00, (k == 5)};
            px[0] = 8'(50 + k);
            step();
            chk("iso_x99", int'(x == 8'd99), 0);
            chk("iso_gnt", int'(gnt), (k == 5) ? 0 : 1);
        end
        req = '0; last = '0;
        step();

        // Random traffic: dense phase, then sparse phase that provokes timeouts.
        do_reset();
        abort_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                req[i]  = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 15) == 0);
                last[i] = ($urandom_range(0, 3) == 0);
                px[i] = 8'($urandom);
                py[i] = 7'($urandom);
                pc[i] = 3'($urandom);
            end
            step();
            if (abort != 0) abort_seen++;
        end
        chk("rand_timeouts_hit", int'(abort_seen > 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

Round-robin arbiter that shares the single `vga_adapter` plot port between up to N sprite drawing engines (enemy, player, bullet controllers). Each engine requests the port and owns it for one complete burst of pixels, terminated by a `last` flag. Ownership then rotates, so no sprite is ever half-drawn and no engine is starved. The block replaces per-cycle muxing of drawer outputs and sits directly in front of the `vga_adapter` `x`/`y`/`colour`/`plot` inputs.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..8.
- `TIMEOUT`, 15: consecutive non-requesting cycles of the owner before forced release, 1..255.

Ports:
- `CLOCK_50`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  N  requester i has a valid pixel on its bus.
- `last`  in  N  requester i's current pixel is the final pixel of its burst.
- `x_in`  in  8*N  pixel x; requester i at bits [8i+7:8i].
- `y_in`  in  7*N  pixel y; requester i at bits [7i+6:7i].
- `colour_in`  in  3*N  pixel colour; requester i at bits [3i+2:3i].
- `gnt`  out  N  one-hot owner; a pixel is accepted on an edge where `gnt[i] & req[i]`.
- `x`  out  8  registered x to `vga_adapter`.
- `y`  out  7  registered y.
- `colour`  out  3  registered colour.
- `plot`  out  1  registered write enable to `vga_adapter`.
- `busy`  out  1  high while in state BURST.
- `abort`  out  N  one-cycle pulse: requester i lost its grant by timeout.

## Operation
- State is IDLE or BURST. Registers: state, `gnt`, rotating priority pointer `ptr` (0..N-1), idle counter `icnt` (8 bits), output registers.
- IDLE: if `req` is nonzero, pick the first set bit scanning `ptr`, `ptr+1`, …, wrapping modulo N. Set the `gnt` one-hot, clear `icnt`, and go to BURST. If `req` is zero, stay in IDLE. No pixel is accepted in IDLE.
- BURST, owner g:
  - Accept when `req[g]=1`. At the edge, `x`/`y`/`colour` <= requester g's fields, `plot`<=1, `icnt`<=0.
  - Accept with `last[g]=1`: at the same edge, `gnt`<=0, `ptr`<=(g+1) mod N, and go to IDLE.
  - `req[g]=0`: `plot`<=0, `icnt`<=`icnt`+1. When `icnt` reaches TIMEOUT-1 and `req[g]` is still 0, the next edge does the same release as `last`, and `abort[g]` is pulsed for one cycle.
- `req`/`last` of non-owners are ignored in BURST. Non-owners must hold their pixel stable until granted.
- `last` is only meaningful together with `req`.
- Output registers hold their previous `x`/`y`/`colour` when `plot`=0.
- Reset, asynchronous, at any time including mid-burst: state=IDLE, `gnt`=0, `ptr`=0, `icnt`=0, `x`=0, `y`=0, `colour`=0, `plot`=0, `busy`=0, `abort`=0. A burst interrupted by reset is not resumed; the requester restarts its sprite.

## Timing
- Request to grant: `req` seen high at edge k (IDLE) gives `gnt` high after edge k. The first accept is at edge k+1.
- Accept to plot: a pixel accepted at edge t appears on `x`/`y`/`colour` with `plot`=1 after edge t, i.e. 1-cycle latency.
- Throughput: 1 pixel/cycle while the owner holds `req`. An M-pixel burst occupies M BURST cycles. One mandatory IDLE cycle follows between bursts.
- `gnt` falls after the edge that accepts `last`. `plot` for that last pixel is high in the same cycle `gnt` is low.
- Timeout: the owner idle for TIMEOUT consecutive cycles loses `gnt` after the TIMEOUT-th idle edge.
- Simultaneous requests in IDLE are resolved purely by `ptr`; there is no fixed priority.

## Test plan
- Reset: assert `reset` asynchronously mid-burst (between clock edges) -> all outputs 0 immediately. After release, `req`=4'b1000 gives `gnt`=4'b1000 (pointer 0 scans past 0..2).
- Single burst: requester 1 drives 16 pixels x=10..25, y=20, colour=3'b100, `last` on x=25 -> `plot` high 16 consecutive cycles with x=10..25 each one cycle after its accept; `gnt` drops after x=25 is accepted; `ptr`=2.
- Round robin: `req`=4'b1111 held, 4-pixel bursts each -> grant order 0,1,2,3,0 with exactly one IDLE cycle between bursts.
- Stalled owner: requester 2 granted, drops `req` after 3 pixels, TIMEOUT=15 -> `gnt[2]` released after 15 idle edges; `abort`=4'b0100 for one cycle; requester 3 granted next.
- Gapped burst: owner toggles `req` 1,0,1,0 (gaps shorter than TIMEOUT) -> `plot` follows 1 cycle later, no abort, burst completes on `last`.
- Non-owner isolation: requester 0 owns; requester 3 toggles `req`/`last` with x=99 -> x never shows 99 and `gnt` never changes until requester 0's `last`.
